// File: rtl/frame_capture_pkg.sv
// Shared types and crop-geometry helpers for the camera frame capture sequencer.
package frame_capture_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    WAIT_VSYNC,
    CAPTURE,
    DRAIN
  } state_t;

  // First coordinate of a window of size `active` centered in `full`.
  function automatic int crop_offset(input int full, input int active);
    return (full - active) / 2;
  endfunction

  function automatic int crop_last(input int full, input int active);
    return crop_offset(full, active) + active - 1;
  endfunction

endpackage

// File: rtl/frame_capture_ctrl_if.sv
// Sensor, capture-request and pixel-sink signals of the frame capture sequencer.
interface frame_capture_ctrl_if #(
  parameter int PixelBitWidth = 16
);

  logic                     i_vsync;
  logic                     i_href;
  logic [PixelBitWidth-1:0] i_pix_data;
  logic                     i_pix_valid;
  logic                     i_capture_req;
  logic                     o_capture_ack;
  logic                     i_sink_ready;
  logic [PixelBitWidth-1:0] o_pix_data;
  logic                     o_pix_valid;
  logic                     o_frame_start;
  logic                     o_frame_end;
  logic                     o_frame_err;
  logic                     o_overflow;
  logic                     o_busy;

  // Environment side: sensor, requester and sink.
  modport master (
    output i_vsync, i_href, i_pix_data, i_pix_valid, i_capture_req, i_sink_ready,
    input  o_capture_ack, o_pix_data, o_pix_valid, o_frame_start, o_frame_end,
           o_frame_err, o_overflow, o_busy
  );

  // Controller side.
  modport slave (
    input  i_vsync, i_href, i_pix_data, i_pix_valid, i_capture_req, i_sink_ready,
    output o_capture_ack, o_pix_data, o_pix_valid, o_frame_start, o_frame_end,
           o_frame_err, o_overflow, o_busy
  );

endinterface

// File: rtl/frame_capture_ctrl_sync_edge.sv
// Two-flop synchronizer followed by an edge register; exposes level, rise and fall.
module sync_edge (
  input  logic p_clk,
  input  logic RST,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       level_d;

  always_ff @(posedge p_clk) begin
    if (!RST) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample its pre-edge input;
      // blocking ones here would collapse the synchronizer chain into one stage.
      sync_q  <= {sync_q[0], raw};
      level_d <= sync_q[1];
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~level_d;
  assign fall  = ~sync_q[1] & level_d;

endmodule

// File: rtl/frame_capture_ctrl.sv
// Capture sequencer: arms on request, aligns to frame start, crops to the centered
// window and forwards pixels through a one-entry holding register.
module frame_capture_ctrl
  import frame_capture_pkg::*;
#(
  parameter int FrameWidth        = 640,
  parameter int FrameHeight       = 480,
  parameter int ActiveFrameWidth  = 512,
  parameter int ActiveFrameHeight = 384,
  parameter int PixelBitWidth     = 16
) (
  input  logic                p_clk,
  input  logic                RST,
  input  logic                i_cfg_done,
  frame_capture_ctrl_if.slave bus
);

  localparam int XW = $clog2(FrameWidth);
  localparam int YW = $clog2(FrameHeight);

  localparam logic [XW-1:0] X_FIRST = XW'(crop_offset(FrameWidth, ActiveFrameWidth));
  localparam logic [XW-1:0] X_LAST  = XW'(crop_last(FrameWidth, ActiveFrameWidth));
  localparam logic [XW-1:0] X_MAX   = XW'(FrameWidth - 1);
  localparam logic [YW-1:0] Y_FIRST = YW'(crop_offset(FrameHeight, ActiveFrameHeight));
  localparam logic [YW-1:0] Y_LAST  = YW'(crop_last(FrameHeight, ActiveFrameHeight));
  localparam logic [YW-1:0] Y_MAX   = YW'(FrameHeight - 1);

  logic cfg_level, cfg_rise, cfg_fall;
  logic vs_level, vs_rise, vs_fall;
  logic hs_level, hs_rise, hs_fall;

  sync_edge u_sync_cfg (
    .p_clk (p_clk), .RST (RST), .raw (i_cfg_done),
    .level (cfg_level), .rise (cfg_rise), .fall (cfg_fall)
  );

  sync_edge u_sync_vsync (
    .p_clk (p_clk), .RST (RST), .raw (bus.i_vsync),
    .level (vs_level), .rise (vs_rise), .fall (vs_fall)
  );

  sync_edge u_sync_href (
    .p_clk (p_clk), .RST (RST), .raw (bus.i_href),
    .level (hs_level), .rise (hs_rise), .fall (hs_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{cfg_rise, cfg_fall, vs_level, vs_fall, hs_rise};

  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic          pix_strobe;

  assign pix_strobe = bus.i_pix_valid & hs_level;

  always_ff @(posedge p_clk) begin
    if (!RST) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (vs_rise) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (hs_fall) begin
      x_cnt <= '0;
      if (y_cnt != Y_MAX) y_cnt <= y_cnt + YW'(1);
    end else if (pix_strobe && x_cnt != X_MAX) begin
      x_cnt <= x_cnt + XW'(1);
    end
  end

  logic in_window, is_first, is_last;

  assign in_window = pix_strobe &&
                     (x_cnt >= X_FIRST) && (x_cnt <= X_LAST) &&
                     (y_cnt >= Y_FIRST) && (y_cnt <= Y_LAST);
  assign is_first  = (x_cnt == X_FIRST) && (y_cnt == Y_FIRST);
  assign is_last   = in_window && (x_cnt == X_LAST) && (y_cnt == Y_LAST);

  state_t                   state, state_nxt;
  logic                     err_flag, err_nxt;
  logic                     hold_valid;
  logic [PixelBitWidth-1:0] hold_data;
  logic                     room;
  logic                     load, drop, ack_set, end_set, ovf_clr;
  logic                     capture_ack, frame_start, frame_end, frame_err, overflow;

  assign room = !hold_valid || bus.i_sink_ready;

  always_comb begin
    // NOTE: every signal gets its default before the case, so no path through
    // it can leave a value unassigned and infer a latch.
    state_nxt = state;
    err_nxt   = err_flag;
    load      = 1'b0;
    drop      = 1'b0;
    ack_set   = 1'b0;
    end_set   = 1'b0;
    ovf_clr   = 1'b0;
    case (state)
      IDLE: if (cfg_level) state_nxt = ARMED;
      ARMED: begin
        if (bus.i_capture_req) begin
          ack_set   = 1'b1;
          ovf_clr   = 1'b1;
          state_nxt = WAIT_VSYNC;
        end
      end
      WAIT_VSYNC: if (vs_rise) state_nxt = CAPTURE;
      CAPTURE: begin
        // A vsync edge aborts the frame unless it coincides with the last pixel.
        if (in_window && (!vs_rise || is_last)) begin
          if (room) begin
            load = 1'b1;
            if (is_last) state_nxt = DRAIN;
          end else begin
            drop = 1'b1;
          end
        end
        if (vs_rise && !(load && is_last)) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!hold_valid) begin
          end_set   = 1'b1;
          err_nxt   = 1'b0;
          state_nxt = ARMED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (!RST) begin
      state       <= IDLE;
      err_flag    <= 1'b0;
      hold_valid  <= 1'b0;
      // NOTE: the pixel data register is reset as well, so o_pix_data reads 0
      // after reset instead of exposing a discarded in-flight pixel.
      hold_data   <= '0;
      capture_ack <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_err   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      err_flag    <= err_nxt;
      capture_ack <= ack_set;
      frame_start <= load & is_first;
      frame_end   <= end_set;
      frame_err   <= end_set & err_flag;
      if (ovf_clr)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
      if (load) begin
        hold_valid <= 1'b1;
        hold_data  <= bus.i_pix_data;
      end else if (bus.i_sink_ready) begin
        hold_valid <= 1'b0;
      end
    end
  end

  assign bus.o_pix_valid   = hold_valid;
  assign bus.o_pix_data    = hold_data;
  assign bus.o_capture_ack = capture_ack;
  assign bus.o_frame_start = frame_start;
  assign bus.o_frame_end   = frame_end;
  assign bus.o_frame_err   = frame_err;
  assign bus.o_overflow    = overflow;
  assign bus.o_busy        = (state == WAIT_VSYNC) || (state == CAPTURE) || (state == DRAIN);

endmodule
